// File: rtl/riscv_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pipe_ctrl_pkg : shared types for the RV32I pipeline hazard controller
// Rev 1.0
// ============================================================================
package riscv_pipe_ctrl_pkg;

  localparam int PCTRL_CNT_W = 16;

  typedef enum logic [1:0] {
    PCTRL_RUN   = 2'd0,
    PCTRL_DWAIT = 2'd1,
    PCTRL_DRAIN = 2'd2
  } pctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_clr;
    logic idex_clr;
    logic exmem_clr;
    logic memwb_clr;
  } pipe_ctl_t;

  // Whole-pipeline control patterns: {pc,ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_clr
  localparam pipe_ctl_t CTL_GO     = pipe_ctl_t'(9'b11111_0000);
  localparam pipe_ctl_t CTL_FREEZE = pipe_ctl_t'(9'b00000_0000);
  localparam pipe_ctl_t CTL_BUBBLE = pipe_ctl_t'(9'b00111_0100);
  localparam pipe_ctl_t CTL_RESET  = pipe_ctl_t'(9'b00000_1111);

endpackage : riscv_pipe_ctrl_pkg
`default_nettype wire

// File: rtl/riscv_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// riscv_pipe_ctrl_if : hazard inputs and stage-register controls of the pipeline
// Rev 1.0
// ============================================================================
interface riscv_pipe_ctrl_if
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = PCTRL_CNT_W
);
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_rs1_en;
  logic             i_id_rs2_en;
  logic             i_id_fence;
  logic [4:0]       i_ex_rd;
  logic             i_ex_we;
  logic             i_ex_load;
  logic             i_ex_valid;
  logic             i_mem_valid;
  logic             i_wb_valid;
  logic             i_ex_redirect;
  logic             i_imem_ack;
  logic             i_dmem_req;
  logic             i_dmem_ack;

  logic             o_pc_en;
  logic             o_ifid_en;
  logic             o_idex_en;
  logic             o_exmem_en;
  logic             o_memwb_en;
  logic             o_ifid_clr;
  logic             o_idex_clr;
  logic             o_exmem_clr;
  logic             o_memwb_clr;
  logic             o_dmem_err;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // Datapath side: reports stage contents, obeys the controls.
  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_id_fence,
           i_ex_rd, i_ex_we, i_ex_load, i_ex_valid, i_mem_valid, i_wb_valid,
           i_ex_redirect, i_imem_ack, i_dmem_req, i_dmem_ack,
    input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
           o_ifid_clr, o_idex_clr, o_exmem_clr, o_memwb_clr,
           o_dmem_err, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_en, i_id_rs2_en, i_id_fence,
           i_ex_rd, i_ex_we, i_ex_load, i_ex_valid, i_mem_valid, i_wb_valid,
           i_ex_redirect, i_imem_ack, i_dmem_req, i_dmem_ack,
    output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
           o_ifid_clr, o_idex_clr, o_exmem_clr, o_memwb_clr,
           o_dmem_err, o_stall_cnt, o_flush_cnt
  );

endinterface : riscv_pipe_ctrl_if
`default_nettype wire

// File: rtl/riscv_sat_counter.sv
`default_nettype none
// ============================================================================
// riscv_sat_counter : up-counter that sticks at all-ones
// Rev 1.0
// ============================================================================
module riscv_sat_counter
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = PCTRL_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule : riscv_sat_counter
`default_nettype wire

// File: rtl/riscv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// riscv_pipe_ctrl : freeze / redirect / load-use / fence / fetch-wait sequencing
// Rev 1.0
// ============================================================================
module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = PCTRL_CNT_W,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  riscv_pipe_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);

  pctrl_state_e      state_q;
  pctrl_state_e      state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              dmem_err_q;
  logic              dmem_err_d;

  pipe_ctl_t         ctl;
  logic              load_use;
  logic              fence_wait;
  logic              timeout;
  logic              freeze;
  logic              flush_inc;
  logic              stall_inc;

  always_comb begin
    load_use   = bus.i_ex_load && bus.i_ex_we && (bus.i_ex_rd != 5'd0) &&
                 ((bus.i_id_rs1_en && (bus.i_id_rs1 == bus.i_ex_rd)) ||
                  (bus.i_id_rs2_en && (bus.i_id_rs2 == bus.i_ex_rd)));
    fence_wait = bus.i_id_fence &&
                 (bus.i_ex_valid || bus.i_mem_valid || bus.i_wb_valid);
    // The error pulse marks the cycle the stuck access is forcibly retired.
    timeout    = dmem_err_q && (state_q == PCTRL_DWAIT);
    freeze     = bus.i_dmem_req && !bus.i_dmem_ack && !timeout;
  end

  always_comb begin
    ctl        = CTL_GO;
    state_d    = PCTRL_RUN;
    wait_cnt_d = '0;
    dmem_err_d = 1'b0;
    flush_inc  = 1'b0;

    if (freeze) begin
      ctl        = CTL_FREEZE;
      state_d    = PCTRL_DWAIT;
      wait_cnt_d = (state_q == PCTRL_DWAIT) ? wait_cnt_q + WAIT_W'(1) : WAIT_W'(1);
      dmem_err_d = (wait_cnt_d >= WAIT_LAST);
    end else begin
      if (bus.i_ex_redirect) begin
        ctl.ifid_clr = 1'b1;
        ctl.idex_clr = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        ctl = CTL_BUBBLE;
      end else if (fence_wait) begin
        ctl     = CTL_BUBBLE;
        state_d = PCTRL_DRAIN;
      end else if (!bus.i_imem_ack) begin
        ctl.pc_en    = 1'b0;
        ctl.ifid_clr = 1'b1;
      end
      if (timeout) begin
        ctl.memwb_clr = 1'b1;
      end
    end

    if (!i_rstn) begin
      ctl = CTL_RESET;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= PCTRL_RUN;
      wait_cnt_q <= '0;
      dmem_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dmem_err_q <= dmem_err_d;
    end
  end

  assign stall_inc = !ctl.pc_en;

  riscv_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_inc  (stall_inc),
    .o_cnt  (bus.o_stall_cnt)
  );

  riscv_sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_inc  (flush_inc),
    .o_cnt  (bus.o_flush_cnt)
  );

  assign bus.o_pc_en     = ctl.pc_en;
  assign bus.o_ifid_en   = ctl.ifid_en;
  assign bus.o_idex_en   = ctl.idex_en;
  assign bus.o_exmem_en  = ctl.exmem_en;
  assign bus.o_memwb_en  = ctl.memwb_en;
  assign bus.o_ifid_clr  = ctl.ifid_clr;
  assign bus.o_idex_clr  = ctl.idex_clr;
  assign bus.o_exmem_clr = ctl.exmem_clr;
  assign bus.o_memwb_clr = ctl.memwb_clr;
  assign bus.o_dmem_err  = dmem_err_q;

endmodule : riscv_pipe_ctrl
`default_nettype wire

// File: tb/tb_riscv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_riscv_pipe_ctrl : directed vectors for the pipeline hazard controller
// Rev 1.0
// ============================================================================
module tb_riscv_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  // {pc,ifid,idex,exmem,memwb}_en, {ifid,idex,exmem,memwb}_clr
  localparam logic [8:0] E_GO     = 9'b11111_0000;
  localparam logic [8:0] E_FREEZE = 9'b00000_0000;
  localparam logic [8:0] E_BUBBLE = 9'b00111_0100;
  localparam logic [8:0] E_REDIR  = 9'b11111_1100;
  localparam logic [8:0] E_FETCHW = 9'b01111_1000;
  localparam logic [8:0] E_RESET  = 9'b00000_1111;
  localparam logic [8:0] E_TMOREL = 9'b11111_0001;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  riscv_pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  riscv_pipe_ctrl #(
    .CNT_W        (CNT_W),
    .DMEM_TIMEOUT (TMO)
  ) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  logic [8:0] ctl_obs;
  assign ctl_obs = {bus.o_pc_en, bus.o_ifid_en, bus.o_idex_en, bus.o_exmem_en, bus.o_memwb_en,
                    bus.o_ifid_clr, bus.o_idex_clr, bus.o_exmem_clr, bus.o_memwb_clr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_id_rs1      = 5'd0;
    bus.i_id_rs2      = 5'd0;
    bus.i_id_rs1_en   = 1'b0;
    bus.i_id_rs2_en   = 1'b0;
    bus.i_id_fence    = 1'b0;
    bus.i_ex_rd       = 5'd0;
    bus.i_ex_we       = 1'b0;
    bus.i_ex_load     = 1'b0;
    bus.i_ex_valid    = 1'b0;
    bus.i_mem_valid   = 1'b0;
    bus.i_wb_valid    = 1'b0;
    bus.i_ex_redirect = 1'b0;
    bus.i_imem_ack    = 1'b1;
    bus.i_dmem_req    = 1'b0;
    bus.i_dmem_ack    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_en,
                          input logic [4:0] rs2, input logic rs2_en);
    bus.i_ex_load   = 1'b1;
    bus.i_ex_we     = 1'b1;
    bus.i_ex_rd     = rd;
    bus.i_id_rs1    = rs1;
    bus.i_id_rs1_en = rs1_en;
    bus.i_id_rs2    = rs2;
    bus.i_id_rs2_en = rs2_en;
  endtask

  task automatic set_valids(input logic [2:0] v);
    {bus.i_ex_valid, bus.i_mem_valid, bus.i_wb_valid} = v;
  endtask

  // Seven frozen cycles, then the forced release with the error pulse.
  task automatic run_timeout(input string tag);
    for (int i = 1; i < TMO; i++) begin
      @(negedge clk);
      bus.i_dmem_req = 1'b1;
      bus.i_dmem_ack = 1'b0;
      #1;
      check_eq({tag, "_freeze"}, 32'(ctl_obs), 32'(E_FREEZE));
      check_eq({tag, "_noerr"}, 32'(bus.o_dmem_err), 32'd0);
    end
    @(negedge clk);
    #1;
    check_eq({tag, "_err"}, 32'(bus.o_dmem_err), 32'd1);
    check_eq({tag, "_release"}, 32'(ctl_obs), 32'(E_TMOREL));
    @(negedge clk);
    bus.i_dmem_req = 1'b0;
    #1;
    check_eq({tag, "_err_gone"}, 32'(bus.o_dmem_err), 32'd0);
    check_eq({tag, "_run"}, 32'(ctl_obs), 32'(E_GO));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_ctl", 32'(ctl_obs), 32'(E_RESET));
    check_eq("rst_stall", 32'(bus.o_stall_cnt), 32'd0);
    check_eq("rst_flush", 32'(bus.o_flush_cnt), 32'd0);
    check_eq("rst_err", 32'(bus.o_dmem_err), 32'd0);
    rstn = 1'b1;
    #1;
    check_eq("first_run", 32'(ctl_obs), 32'(E_GO));

    // Load-use and redirect priorities, counters accumulate across these cycles
    @(negedge clk); set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); #1;
    check_eq("lu_rs2", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); idle_inputs(); #1;
    check_eq("lu_one_bubble", 32'(ctl_obs), 32'(E_GO));
    check_eq("lu_stall1", 32'(bus.o_stall_cnt), 32'd1);
    @(negedge clk); set_load(5'd0, 5'd0, 1'b0, 5'd0, 1'b1); #1;
    check_eq("lu_x0", 32'(ctl_obs), 32'(E_GO));
    @(negedge clk); set_load(5'd7, 5'd7, 1'b0, 5'd3, 1'b1); #1;
    check_eq("lu_rs1_unused", 32'(ctl_obs), 32'(E_GO));
    @(negedge clk); set_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b1); #1;
    check_eq("lu_rs1", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); set_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b1); bus.i_ex_we = 1'b0; #1;
    check_eq("lu_no_we", 32'(ctl_obs), 32'(E_GO));
    @(negedge clk); idle_inputs(); bus.i_ex_redirect = 1'b1; #1;
    check_eq("redir", 32'(ctl_obs), 32'(E_REDIR));
    check_eq("redir_flush0", 32'(bus.o_flush_cnt), 32'd0);
    @(negedge clk); idle_inputs(); bus.i_imem_ack = 1'b0; #1;
    check_eq("redir_flush1", 32'(bus.o_flush_cnt), 32'd1);
    check_eq("fetch_wait", 32'(ctl_obs), 32'(E_FETCHW));
    @(negedge clk); idle_inputs(); set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    bus.i_ex_redirect = 1'b1; bus.i_imem_ack = 1'b0; #1;
    check_eq("redir_beats_lu", 32'(ctl_obs), 32'(E_REDIR));
    @(negedge clk); idle_inputs(); #1;
    check_eq("a_stall", 32'(bus.o_stall_cnt), 32'd3);
    check_eq("a_flush", 32'(bus.o_flush_cnt), 32'd2);

    // Freeze holds a redirect until the data access completes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_dmem_req = 1'b1; bus.i_dmem_ack = 1'b0; bus.i_ex_redirect = 1'b1;
      #1;
      check_eq("dwait_freeze", 32'(ctl_obs), 32'(E_FREEZE));
    end
    @(negedge clk); bus.i_dmem_ack = 1'b1; #1;
    check_eq("dwait_ack_redir", 32'(ctl_obs), 32'(E_REDIR));
    check_eq("dwait_stall", 32'(bus.o_stall_cnt), 32'd4);
    @(negedge clk); idle_inputs(); #1;
    check_eq("dwait_flush", 32'(bus.o_flush_cnt), 32'd1);
    check_eq("dwait_stall_held", 32'(bus.o_stall_cnt), 32'd4);

    // Timeout, then stall counter saturation
    do_reset();
    run_timeout("tmo");
    check_eq("tmo_stall", 32'(bus.o_stall_cnt), 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); bus.i_imem_ack = 1'b0;
    end
    @(negedge clk); idle_inputs(); #1;
    check_eq("stall_sat", 32'(bus.o_stall_cnt), 32'd15);

    // Fence drain, then a fence aborted by a redirect
    do_reset();
    @(negedge clk); bus.i_id_fence = 1'b1; set_valids(3'b111); #1;
    check_eq("fence_d1", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); set_valids(3'b011); #1;
    check_eq("fence_d2", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); set_valids(3'b001); #1;
    check_eq("fence_d3", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); set_valids(3'b000); #1;
    check_eq("fence_go", 32'(ctl_obs), 32'(E_GO));
    @(negedge clk); idle_inputs(); #1;
    check_eq("fence_stall", 32'(bus.o_stall_cnt), 32'd3);
    @(negedge clk); bus.i_id_fence = 1'b1; set_valids(3'b111); #1;
    check_eq("fence2_d1", 32'(ctl_obs), 32'(E_BUBBLE));
    @(negedge clk); set_valids(3'b011); bus.i_ex_redirect = 1'b1; #1;
    check_eq("fence2_redir", 32'(ctl_obs), 32'(E_REDIR));
    @(negedge clk); idle_inputs(); set_valids(3'b001); #1;
    check_eq("fence2_run", 32'(ctl_obs), 32'(E_GO));
    check_eq("fence2_flush", 32'(bus.o_flush_cnt), 32'd1);
    check_eq("fence2_stall", 32'(bus.o_stall_cnt), 32'd4);

    // Asynchronous reset in the middle of a data wait
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle_inputs(); bus.i_dmem_req = 1'b1; #1;
      check_eq("mid_freeze", 32'(ctl_obs), 32'(E_FREEZE));
    end
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_ctl", 32'(ctl_obs), 32'(E_RESET));
    check_eq("mid_rst_stall", 32'(bus.o_stall_cnt), 32'd0);
    check_eq("mid_rst_flush", 32'(bus.o_flush_cnt), 32'd0);
    bus.i_dmem_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("post_rst_run", 32'(ctl_obs), 32'(E_GO));
    run_timeout("post_rst_tmo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_riscv_pipe_ctrl
`default_nettype wire
